ahb_lite_fifo_slave: RTL and testbench

AHB-Lite slave that exposes a word-wide FIFO through a three-register map. Sits directly downstream of the address decoder: it consumes one HSELx line (default HSEL1, region 0x1000_0000–0x1FFF_FFFF) plus the shared master signals. It returns HRDATA/HREADYOUT/HRESP to the slave-to-master multiplexor.

---
 rtl/ahb_lite_pkg.sv | 33 +++
 rtl/ahb_lite_fifo_mem.sv | 48 ++++
 rtl/ahb_lite_fifo_slave.sv | 150 +++++++++++++++
 tb/tb_ahb_lite_fifo_slave.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - shared AHB-Lite types and FIFO slave register map
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } slave_state_t;

endpackage

// File: rtl/ahb_lite_fifo_mem.sv
// rtl/ahb_lite_fifo_mem.sv - single-port FIFO storage with pointers, count and flags
module ahb_lite_fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // storage is never cleared; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally since DEPTH is a power of two; flush wins
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      count  <= count + CNT_W'(1);
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count - CNT_W'(1);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ahb_lite_fifo_slave.sv
// rtl/ahb_lite_fifo_slave.sv - AHB-Lite FIFO slave; ERROR responses enabled by AHB_FIFO_ERR_EN
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module ahb_lite_fifo_slave
  import ahb_lite_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = `BUS_WIDTH
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [`BUS_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  fifo_full,
  output logic                  fifo_empty
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  slave_state_t          state, state_nx;
  htrans_t               trans;
  logic                  accept, a_bad, in_data, push, pop, flush;
  logic [1:0]            a_off, d_off;
  logic                  d_write, d_bad;
  logic [CNT_W-1:0]      count, cnt_proj;
  logic [DATA_WIDTH-1:0] head, status_word;
  logic                  unused_addr;

  assign trans       = htrans_t'(HTRANS);
  assign a_off       = HADDR[3:2];
  assign unused_addr = ^{HADDR[`BUS_WIDTH-1:4], HADDR[1:0]};
  assign accept      = HSEL && HREADY && (state != ST_ERR1) &&
                       (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

  // a rejected transfer reaches ACCESS only when errors are disabled, and then does nothing
  assign in_data = (state == ST_ACCESS) && !d_bad;
  assign push    = in_data &&  d_write && (d_off == OFF_DATA);
  assign pop     = in_data && !d_write && (d_off == OFF_DATA);
  assign flush   = in_data &&  d_write && (d_off == OFF_CTRL) && HWDATA[0];

  // count as it will stand once the overlapping data phase has completed
  always_comb begin
    cnt_proj = count;
    if (flush)     cnt_proj = '0;
    else if (push) cnt_proj = count + CNT_W'(1);
    else if (pop)  cnt_proj = count - CNT_W'(1);
  end

  // address-phase legality: bad size, unmapped, STATUS write, overflow, underflow
  always_comb begin
    a_bad = (HSIZE != HSIZE_WORD) || (a_off == 2'd3) || (HWRITE && a_off == OFF_STATUS);
    if (a_off == OFF_DATA) begin
      if (HWRITE && cnt_proj == CNT_W'(DEPTH)) a_bad = 1'b1;
      if (!HWRITE && cnt_proj == '0)           a_bad = 1'b1;
    end
  end

  // capture the accepted address phase for use in its data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      d_off   <= OFF_DATA;
      d_write <= 1'b0;
      d_bad   <= 1'b0;
    end else if (accept) begin
      d_off   <= a_off;
      d_write <= HWRITE;
      d_bad   <= a_bad;
    end
  end

  // protocol state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nx;
  end

`ifdef AHB_FIFO_ERR_EN
  // next state and response: two-cycle ERROR for rejected transfers
  always_comb begin
    state_nx  = ST_IDLE;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      ST_ERR1: begin
        state_nx  = ST_ERR2;
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      default: begin
        if (state == ST_ERR2) HRESP = HRESP_ERROR;
        if (accept) state_nx = a_bad ? ST_ERR1 : ST_ACCESS;
      end
    endcase
  end
`else
  // next state and response: every transfer is a zero-wait OKAY
  always_comb begin
    state_nx  = accept ? ST_ACCESS : ST_IDLE;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
  end
`endif

  ahb_lite_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_mem (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (HWDATA),
    .head  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // STATUS layout: count from bit 8, full at bit 1, empty at bit 0
  always_comb begin
    status_word              = '0;
    status_word[8 +: CNT_W]  = count;
    status_word[1]           = fifo_full;
    status_word[0]           = fifo_empty;
  end

  // read data only during a good read data phase; CONTROL reads as 0
  always_comb begin
    HRDATA = '0;
    if (in_data && !d_write) begin
      case (d_off)
        OFF_DATA:   HRDATA = head;
        OFF_STATUS: HRDATA = status_word;
        default:    HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_fifo_slave.sv
// tb/tb_ahb_lite_fifo_slave.sv - randomized self-checking bench with queue reference model
`timescale 1ns/1ps

module tb_ahb_lite_fifo_slave;
  localparam int DEPTH = 8;
`ifdef AHB_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, fifo_full, fifo_empty;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_lite_fifo_slave #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  typedef struct { logic sel; logic [1:0] trans; logic [31:0] addr; logic write; logic [2:0] size; logic [31:0] wdata; } xfer_t;
  typedef struct { logic err; logic [31:0] rdata; } exp_t;
  typedef struct { logic ready; logic resp; logic resp_last; int waits; logic [31:0] rdata; } obs_t;

  xfer_t       pend[$];
  exp_t        expq[$];
  obs_t        obs[$];
  logic [31:0] mq[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // reference model: transfers take effect strictly in bus order
  function automatic exp_t model(input xfer_t t);
    exp_t e;
    int   off;
    logic bad;
    e.err = 1'b0;
    e.rdata = 32'h0;
    off = int'(t.addr[3:2]);
    if (!(t.sel && t.trans[1])) return e;
    bad = (t.size != 3'b010) || (off == 3) || (t.write && off == 1) ||
          (t.write && off == 0 && mq.size() == DEPTH) || (!t.write && off == 0 && mq.size() == 0);
    if (bad) begin
      e.err = ERR_EN;
      return e;
    end
    case (off)
      0: if (t.write) mq.push_back(t.wdata); else e.rdata = mq.pop_front();
      1: if (!t.write) e.rdata = (32'(mq.size()) << 8) | (32'(mq.size() == DEPTH) << 1) | 32'(mq.size() == 0);
      default: if (t.write && t.wdata[0]) mq.delete();
    endcase
    return e;
  endfunction

  task automatic add_x(input xfer_t t);
    pend.push_back(t);
    expq.push_back(model(t));
  endtask

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d);
    xfer_t t;
    t.sel = 1'b1; t.trans = 2'b10; t.addr = a; t.write = w; t.size = 3'b010; t.wdata = d;
    add_x(t);
  endtask

  task automatic drive(input int idx);
    if (idx < pend.size()) begin
      HSEL = pend[idx].sel; HTRANS = pend[idx].trans; HADDR = pend[idx].addr;
      HWRITE = pend[idx].write; HSIZE = pend[idx].size;
    end else begin
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    end
  endtask

  // pipelined driver: records what the bus shows during each data phase
  task automatic run;
    obs.delete();
    @(posedge HCLK); #1;
    drive(0);
    for (int i = 0; i < pend.size(); i++) begin
      obs_t o;
      @(posedge HCLK); #1;
      HWDATA = pend[i].wdata;
      drive(i + 1);
      @(negedge HCLK);
      o.ready = HREADYOUT; o.resp = HRESP; o.resp_last = HRESP; o.rdata = HRDATA; o.waits = 0;
      while (HREADYOUT !== 1'b1 && o.waits < 4) begin
        @(posedge HCLK); #1;
        @(negedge HCLK);
        o.waits++;
        o.resp_last = HRESP;
      end
      obs.push_back(o);
    end
    @(posedge HCLK); #1;
    pend.delete();
  endtask

  task automatic test_reset;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h1000_0000;
    HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    mq.delete();
    @(negedge HCLK);
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout: got %b want 1", HREADYOUT); end
    n_cmp++; if (HRESP !== 1'b0) begin n_bad++; $display("FAIL reset_hresp: got %b want 0", HRESP); end
    n_cmp++; if (HRDATA !== 32'h0) begin n_bad++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
    n_cmp++; if ({fifo_full, fifo_empty} !== 2'b01) begin n_bad++; $display("FAIL reset_flags: got full/empty %b want 01", {fifo_full, fifo_empty}); end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 8; i++) add(1'b1, 32'h1000_0000, 32'hA5A5_0001 + i);
    add(1'b0, 32'h1000_0004, 32'h0);
    for (int i = 0; i < 8; i++) add(1'b0, 32'h1000_0000, 32'h0);
    add(1'b0, 32'h1000_0004, 32'h0);
    run;
    foreach (obs[i]) begin
      n_cmp++;
      if ({obs[i].ready, obs[i].resp, obs[i].resp_last, 3'(obs[i].waits)} !== {~expq[i].err, expq[i].err, expq[i].err, 3'(expq[i].err)}) begin
        n_bad++; $display("FAIL fill_resp[%0d]: got rdy=%b resp=%b/%b waits=%0d want err=%b", i, obs[i].ready, obs[i].resp, obs[i].resp_last, obs[i].waits, expq[i].err);
      end
      n_cmp++; if (obs[i].rdata !== expq[i].rdata) begin n_bad++; $display("FAIL fill_rdata[%0d]: got %h want %h", i, obs[i].rdata, expq[i].rdata); end
    end
    n_cmp++; if (obs[8].rdata !== 32'h0000_0802) begin n_bad++; $display("FAIL fill_status: got %h want 00000802", obs[8].rdata); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (obs[9 + i].rdata !== 32'hA5A5_0001 + i) begin n_bad++; $display("FAIL drain_order[%0d]: got %h want %h", i, obs[9 + i].rdata, 32'hA5A5_0001 + i); end
    end
    n_cmp++; if (obs[17].rdata !== 32'h0000_0001) begin n_bad++; $display("FAIL drain_status: got %h want 00000001", obs[17].rdata); end
    expq.delete();
  endtask

  task automatic test_full_write;
    for (int i = 0; i < 8; i++) add(1'b1, 32'h1000_0000, 32'hA5A5_0001 + i);
    add(1'b1, 32'h1000_0000, 32'hDEAD_BEEF);
    add(1'b0, 32'h1000_0004, 32'h0);
    add(1'b0, 32'h1000_0000, 32'h0);
    run;
    foreach (obs[i]) begin
      n_cmp++;
      if ({obs[i].ready, obs[i].resp, obs[i].resp_last, 3'(obs[i].waits)} !== {~expq[i].err, expq[i].err, expq[i].err, 3'(expq[i].err)}) begin
        n_bad++; $display("FAIL full_resp[%0d]: got rdy=%b resp=%b/%b waits=%0d want err=%b", i, obs[i].ready, obs[i].resp, obs[i].resp_last, obs[i].waits, expq[i].err);
      end
      n_cmp++; if (obs[i].rdata !== expq[i].rdata) begin n_bad++; $display("FAIL full_rdata[%0d]: got %h want %h", i, obs[i].rdata, expq[i].rdata); end
    end
`ifdef AHB_FIFO_ERR_EN
    n_cmp++; if ({obs[8].ready, obs[8].resp, obs[8].resp_last} !== 3'b011) begin n_bad++; $display("FAIL full_err_seq: got rdy/resp/resp2 %b want 011", {obs[8].ready, obs[8].resp, obs[8].resp_last}); end
`endif
    n_cmp++; if (obs[9].rdata !== 32'h0000_0802) begin n_bad++; $display("FAIL full_status: got %h want 00000802", obs[9].rdata); end
    n_cmp++; if (obs[10].rdata !== 32'hA5A5_0001) begin n_bad++; $display("FAIL full_head: got %h want a5a50001", obs[10].rdata); end
    expq.delete();
  endtask

  task automatic test_flush;
    add(1'b0, 32'h1000_0000, 32'h0);
    add(1'b0, 32'h1000_0000, 32'h0);
    add(1'b1, 32'h1000_0008, 32'h0000_0001);
    add(1'b0, 32'h1000_0004, 32'h0);
    add(1'b1, 32'h1000_0000, 32'h1234_5678);
    add(1'b0, 32'h1000_0000, 32'h0);
    add(1'b0, 32'h1000_0008, 32'h0);
    run;
    foreach (obs[i]) begin
      n_cmp++;
      if ({obs[i].ready, obs[i].resp, obs[i].resp_last, 3'(obs[i].waits)} !== {~expq[i].err, expq[i].err, expq[i].err, 3'(expq[i].err)}) begin
        n_bad++; $display("FAIL flush_resp[%0d]: got rdy=%b resp=%b/%b waits=%0d want err=%b", i, obs[i].ready, obs[i].resp, obs[i].resp_last, obs[i].waits, expq[i].err);
      end
      n_cmp++; if (obs[i].rdata !== expq[i].rdata) begin n_bad++; $display("FAIL flush_rdata[%0d]: got %h want %h", i, obs[i].rdata, expq[i].rdata); end
    end
    n_cmp++; if (obs[3].rdata !== 32'h0000_0001) begin n_bad++; $display("FAIL flush_status: got %h want 00000001", obs[3].rdata); end
    n_cmp++; if (obs[5].rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL flush_roundtrip: got %h want 12345678", obs[5].rdata); end
    expq.delete();
  endtask

  task automatic test_projection;
    add(1'b1, 32'h1000_0000, 32'hCAFE_0001);
    add(1'b0, 32'h1000_0000, 32'h0);
    add(1'b1, 32'h1000_0000, 32'hCAFE_0002);
    add(1'b0, 32'h1000_0000, 32'h0);
    add(1'b0, 32'h1000_0000, 32'h0);
    add(1'b0, 32'h1000_0004, 32'h0);
    run;
    foreach (obs[i]) begin
      n_cmp++;
      if ({obs[i].ready, obs[i].resp, obs[i].resp_last, 3'(obs[i].waits)} !== {~expq[i].err, expq[i].err, expq[i].err, 3'(expq[i].err)}) begin
        n_bad++; $display("FAIL proj_resp[%0d]: got rdy=%b resp=%b/%b waits=%0d want err=%b", i, obs[i].ready, obs[i].resp, obs[i].resp_last, obs[i].waits, expq[i].err);
      end
      n_cmp++; if (obs[i].rdata !== expq[i].rdata) begin n_bad++; $display("FAIL proj_rdata[%0d]: got %h want %h", i, obs[i].rdata, expq[i].rdata); end
    end
    n_cmp++; if ({obs[1].resp, obs[1].rdata} !== {1'b0, 32'hCAFE_0001}) begin n_bad++; $display("FAIL proj_write_read: got resp=%b data=%h want 0/cafe0001", obs[1].resp, obs[1].rdata); end
`ifdef AHB_FIFO_ERR_EN
    n_cmp++; if (obs[4].resp !== 1'b1) begin n_bad++; $display("FAIL proj_pop_last_read: got resp=%b want 1", obs[4].resp); end
`else
    n_cmp++; if ({obs[4].resp, obs[4].rdata} !== 33'h0) begin n_bad++; $display("FAIL proj_pop_last_read: got resp=%b data=%h want 0/0", obs[4].resp, obs[4].rdata); end
`endif
    n_cmp++; if (obs[5].rdata !== 32'h0000_0001) begin n_bad++; $display("FAIL proj_status: got %h want 00000001", obs[5].rdata); end
    expq.delete();
  endtask

  task automatic test_random;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 40; k++) begin
        xfer_t t;
        int    r, off;
        r = int'($urandom_range(0, 19));
        off = (r < 12) ? 0 : (r < 16) ? 1 : (r < 19) ? 2 : 3;
        t.sel   = ($urandom_range(0, 9) != 0);
        t.trans = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        t.write = ($urandom_range(0, 99) < ((b % 2 == 0) ? 70 : 35));
        t.size  = ($urandom_range(0, 15) == 0) ? 3'b001 : 3'b010;
        t.wdata = $urandom;
        if (off == 2 && $urandom_range(0, 3) != 0) t.wdata[0] = 1'b0;
        t.addr  = 32'h1000_0000 | (32'($urandom_range(0, 255)) << 4) | (32'(off) << 2);
        add_x(t);
      end
      run;
      foreach (obs[i]) begin
        n_cmp++;
        if ({obs[i].ready, obs[i].resp, obs[i].resp_last, 3'(obs[i].waits)} !== {~expq[i].err, expq[i].err, expq[i].err, 3'(expq[i].err)}) begin
          n_bad++; $display("FAIL rand_resp[%0d.%0d]: got rdy=%b resp=%b/%b waits=%0d want err=%b", b, i, obs[i].ready, obs[i].resp, obs[i].resp_last, obs[i].waits, expq[i].err);
        end
        n_cmp++; if (obs[i].rdata !== expq[i].rdata) begin n_bad++; $display("FAIL rand_rdata[%0d.%0d]: got %h want %h", b, i, obs[i].rdata, expq[i].rdata); end
      end
      @(negedge HCLK);
      n_cmp++;
      if ({fifo_full, fifo_empty} !== {mq.size() == DEPTH, mq.size() == 0}) begin
        n_bad++; $display("FAIL rand_flags[%0d]: got full/empty %b want count %0d", b, {fifo_full, fifo_empty}, mq.size());
      end
      expq.delete();
    end
  endtask

  task automatic test_reset_mid_err;
    for (int i = 0; i < 3; i++) add(1'b1, 32'h1000_0000, 32'h5500_0000 + i);
    run;
    expq.delete();
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h1000_000C; HWRITE = 1'b0; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
`ifdef AHB_FIFO_ERR_EN
    @(negedge HCLK);
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_bad++; $display("FAIL rst_err1_entry: got rdy/resp %b want 01", {HREADYOUT, HRESP}); end
`endif
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    mq.delete();
    @(negedge HCLK);
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_bad++; $display("FAIL rst_mid_err: got rdy/resp %b want 10", {HREADYOUT, HRESP}); end
    add(1'b0, 32'h1000_0004, 32'h0);
    run;
    n_cmp++; if ({obs[0].ready, obs[0].resp, obs[0].rdata} !== {1'b1, 1'b0, 32'h0000_0001}) begin
      n_bad++; $display("FAIL rst_status: got rdy=%b resp=%b data=%h want 1/0/00000001", obs[0].ready, obs[0].resp, obs[0].rdata);
    end
    expq.delete();
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_full_write;
    test_flush;
    test_projection;
    test_random;
    test_reset_mid_err;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
